// File: rtl/sha_job_sched.sv
// Loads a job header, issues nonces to the hash datapath and reports the first winner; header writes land 1 cycle after each strobe, first issue the cycle after the last word.
// Issue holds off on core_stall or MAX_INFLIGHT outstanding; defining SCHED_TIMEOUT_EN adds a no-response timeout.
module sha_job_sched #(
    parameter int unsigned HDR_WORDS    = 19,
    parameter int unsigned MAX_INFLIGHT = 8,
    parameter logic [31:0] NONCE_LAST   = 32'hFFFF_FFFF
`ifdef SCHED_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC  = 1024
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready,
    input  logic [31:0] data,
    output logic        hdr_we,
    output logic [4:0]  hdr_addr,
    output logic [31:0] hdr_data,
    output logic        core_issue,
    output logic [31:0] core_nonce,
    input  logic        core_stall,
    input  logic        core_valid,
    input  logic        core_success,
    output logic        valid,
    output logic        success,
    output logic [31:0] index,
    output logic        busy
`ifdef SCHED_TIMEOUT_EN
    ,
    output logic        timeout
`endif
);

    localparam int PW = $clog2(MAX_INFLIGHT);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_INFLIGHT);
    localparam logic [4:0]    LAST_WORD = 5'(HDR_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_REPORT
    } state_t;

    state_t         state_q, state_d;
    logic [4:0]     word_q, word_d;
    logic           hdr_we_q, hdr_we_d;
    logic [4:0]     hdr_addr_q, hdr_addr_d;
    logic [31:0]    hdr_data_q, hdr_data_d;
    logic [31:0]    nonce_q, nonce_d;
    logic           last_done_q, last_done_d;
    logic [31:0]    last_nonce_q, last_nonce_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic           win_q, win_d;
    logic [31:0]    result_q, result_d;
    logic [31:0]    mem_q [MAX_INFLIGHT];

    logic           pop;
    logic           hit;
    logic           issue;
    logic           tmo_fire;
    logic [31:0]    head;

    assign pop   = core_valid && (cnt_q != '0);
    assign head  = mem_q[rd_ptr_q];
    assign hit   = pop && core_success && (state_q == S_RUN);
    // A winner seen this cycle blocks the issue in the same cycle.
    assign issue = (state_q == S_RUN) && !last_done_q && (cnt_q < MAX_CNT)
                   && !core_stall && !hit && !tmo_fire;

`ifdef SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0]  tmr_q, tmr_d;
    logic           to_q, to_d;
    logic           tmr_run;

    assign tmr_run  = ((state_q == S_RUN) || (state_q == S_DRAIN)) && (cnt_q != '0) && !pop;
    assign tmo_fire = tmr_run && (tmr_q == TMO_LAST);
    assign tmr_d    = tmr_run ? tmr_q + TW'(1) : '0;
    assign timeout  = valid && to_q;
`else
    assign tmo_fire = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        hdr_we_d     = 1'b0;
        hdr_addr_d   = hdr_addr_q;
        hdr_data_d   = hdr_data_q;
        nonce_d      = nonce_q;
        last_done_d  = last_done_q;
        last_nonce_d = last_nonce_q;
        cnt_d        = cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        win_d        = win_q;
        result_d     = result_q;
`ifdef SCHED_TIMEOUT_EN
        to_d         = to_q;
`endif

        if (issue) begin
            wr_ptr_d     = wr_ptr_q + PW'(1);
            last_nonce_d = nonce_q;
            if (nonce_q == NONCE_LAST) begin
                last_done_d = 1'b1;
            end else begin
                nonce_d = nonce_q + 32'd1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({issue, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        case (state_q)
            S_IDLE, S_LOAD: begin
                if (ready) begin
                    hdr_we_d   = 1'b1;
                    hdr_addr_d = word_q;
                    hdr_data_d = data;
                    if (word_q == LAST_WORD) begin
                        state_d      = S_RUN;
                        word_d       = '0;
                        nonce_d      = '0;
                        last_done_d  = 1'b0;
                        last_nonce_d = '0;
                        cnt_d        = '0;
                        wr_ptr_d     = '0;
                        rd_ptr_d     = '0;
                        win_d        = 1'b0;
                        result_d     = NONCE_LAST;
                    end else begin
                        state_d = S_LOAD;
                        word_d  = word_q + 5'd1;
                    end
                end
            end
            S_RUN: begin
                if (hit) begin
                    win_d    = 1'b1;
                    result_d = head;
                    state_d  = S_DRAIN;
                end else if (last_done_d) begin
                    state_d = (cnt_d != '0) ? S_DRAIN : S_REPORT;
                end
            end
            S_DRAIN: begin
                if (cnt_d == '0) begin
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                state_d = S_IDLE;
`ifdef SCHED_TIMEOUT_EN
                to_d    = 1'b0;
`endif
            end
            default: state_d = S_IDLE;
        endcase

`ifdef SCHED_TIMEOUT_EN
        if (tmo_fire) begin
            state_d  = S_REPORT;
            win_d    = 1'b0;
            result_d = last_nonce_q;
            to_d     = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            word_q       <= '0;
            hdr_we_q     <= 1'b0;
            hdr_addr_q   <= '0;
            hdr_data_q   <= '0;
            nonce_q      <= '0;
            last_done_q  <= 1'b0;
            last_nonce_q <= '0;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            win_q        <= 1'b0;
            result_q     <= '0;
`ifdef SCHED_TIMEOUT_EN
            tmr_q        <= '0;
            to_q         <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            hdr_we_q     <= hdr_we_d;
            hdr_addr_q   <= hdr_addr_d;
            hdr_data_q   <= hdr_data_d;
            nonce_q      <= nonce_d;
            last_done_q  <= last_done_d;
            last_nonce_q <= last_nonce_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            win_q        <= win_d;
            result_q     <= result_d;
`ifdef SCHED_TIMEOUT_EN
            tmr_q        <= tmr_d;
            to_q         <= to_d;
`endif
        end
    end

    // Tag storage holds no state of its own; emptiness lives in cnt_q.
    always_ff @(posedge clk) begin
        if (issue) begin
            mem_q[wr_ptr_q] <= nonce_q;
        end
    end

    assign hdr_we     = hdr_we_q;
    assign hdr_addr   = hdr_addr_q;
    assign hdr_data   = hdr_data_q;
    assign core_issue = issue;
    assign core_nonce = nonce_q;
    assign valid      = (state_q == S_REPORT);
    assign success    = valid && win_q;
    assign index      = valid ? result_q : '0;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sha_job_sched.sv
// Scoreboard bench: a long-nonce scheduler for load/issue/winner/reset cases and a NONCE_LAST=15 scheduler for the exhaustion case.
module tb_sha_job_sched;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } hdr_e_t;

    typedef struct packed {
        logic        s;
        logic [31:0] idx;
        logic        to;
    } rep_e_t;

    typedef struct {
        logic [31:0] n;
        int          due;
    } pipe_e_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready, ready_s;
    logic [31:0] data;
    logic        core_stall;
    logic        core_valid, core_success;
    logic        core_valid_s, core_success_s;

    logic        hdr_we, hdr_we_s;
    logic [4:0]  hdr_addr, hdr_addr_s;
    logic [31:0] hdr_data, hdr_data_s;
    logic        core_issue, core_issue_s;
    logic [31:0] core_nonce, core_nonce_s;
    logic        valid, valid_s, success, success_s, busy, busy_s;
    logic [31:0] index, index_s;
`ifdef SCHED_TIMEOUT_EN
    logic        timeout, timeout_s;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int rep_seen = 0;
    int rep_seen_s = 0;
    bit lat_en = 1'b0;
    bit force_one = 1'b0;

    hdr_e_t      exp_hdr[$];
    logic [31:0] exp_iss[$];
    logic [31:0] exp_iss_s[$];
    rep_e_t      exp_rep[$];
    rep_e_t      exp_rep_s[$];
    pipe_e_t     pipe[$];
    pipe_e_t     pipe_s[$];

    sha_job_sched #(
        .HDR_WORDS(19), .MAX_INFLIGHT(8), .NONCE_LAST(32'hFFFF_FFFF)
`ifdef SCHED_TIMEOUT_EN
        , .TIMEOUT_CYC(16)
`endif
    ) u_dut (
        .clk(clk), .rst(rst), .ready(ready), .data(data),
        .hdr_we(hdr_we), .hdr_addr(hdr_addr), .hdr_data(hdr_data),
        .core_issue(core_issue), .core_nonce(core_nonce), .core_stall(core_stall),
        .core_valid(core_valid), .core_success(core_success),
        .valid(valid), .success(success), .index(index), .busy(busy)
`ifdef SCHED_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    sha_job_sched #(
        .HDR_WORDS(19), .MAX_INFLIGHT(8), .NONCE_LAST(32'd15)
    ) u_short (
        .clk(clk), .rst(rst), .ready(ready_s), .data(data),
        .hdr_we(hdr_we_s), .hdr_addr(hdr_addr_s), .hdr_data(hdr_data_s),
        .core_issue(core_issue_s), .core_nonce(core_nonce_s), .core_stall(core_stall),
        .core_valid(core_valid_s), .core_success(core_success_s),
        .valid(valid_s), .success(success_s), .index(index_s), .busy(busy_s)
`ifdef SCHED_TIMEOUT_EN
        , .timeout(timeout_s)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            if (hdr_we) begin
                if (exp_hdr.size() == 0) chk("hdr_we_unexpected", {31'b0, hdr_we}, 32'd0);
                else begin
                    hdr_e_t e;
                    e = exp_hdr.pop_front();
                    chk("hdr_addr", {27'b0, hdr_addr}, {27'b0, e.a});
                    chk("hdr_data", hdr_data, e.d);
                end
            end
            if (core_issue) begin
                if (exp_iss.size() == 0) chk("issue_unexpected", core_nonce, 32'hFFFF_FFFF);
                else chk("core_nonce", core_nonce, exp_iss.pop_front());
            end
            if (valid) begin
                rep_seen++;
                if (exp_rep.size() == 0) chk("valid_unexpected", {31'b0, valid}, 32'd0);
                else begin
                    rep_e_t r;
                    r = exp_rep.pop_front();
                    chk("rep_success", {31'b0, success}, {31'b0, r.s});
                    chk("rep_index", index, r.idx);
`ifdef SCHED_TIMEOUT_EN
                    chk("rep_timeout", {31'b0, timeout}, {31'b0, r.to});
`endif
                end
            end
            if (core_issue_s) begin
                if (exp_iss_s.size() == 0) chk("short_issue_unexpected", core_nonce_s, 32'hFFFF_FFFF);
                else chk("short_core_nonce", core_nonce_s, exp_iss_s.pop_front());
            end
            if (valid_s) begin
                rep_seen_s++;
                if (exp_rep_s.size() == 0) chk("short_valid_unexpected", {31'b0, valid_s}, 32'd0);
                else begin
                    rep_e_t r;
                    r = exp_rep_s.pop_front();
                    chk("short_rep_success", {31'b0, success_s}, {31'b0, r.s});
                    chk("short_rep_index", index_s, r.idx);
                end
            end
        end
    end

    // Datapath model: record issues, return them in order after 4 cycles.
    always @(negedge clk) begin
        if (rst && core_issue) pipe.push_back('{n: core_nonce, due: cyc + 4});
        if (rst && core_issue_s) pipe_s.push_back('{n: core_nonce_s, due: cyc + 4});
    end

    initial begin
        pipe_e_t e;
        core_valid = 1'b0; core_success = 1'b0;
        core_valid_s = 1'b0; core_success_s = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            core_valid = 1'b0; core_success = 1'b0;
            core_valid_s = 1'b0; core_success_s = 1'b0;
            if (force_one) begin
                force_one = 1'b0;
                if (pipe.size() > 0) begin
                    e = pipe.pop_front();
                    core_valid = 1'b1;
                end
            end else if (lat_en && pipe.size() > 0 && pipe[0].due == cyc) begin
                e = pipe.pop_front();
                core_valid   = 1'b1;
                core_success = (e.n == 32'd13) || (e.n == 32'd15);
            end
            if (pipe_s.size() > 0 && pipe_s[0].due == cyc) begin
                e = pipe_s.pop_front();
                core_valid_s = 1'b1;
            end
        end
    end

    task automatic load(input logic [31:0] base, input bit to_short);
        for (int i = 0; i < 19; i++) begin
            @(posedge clk); #1;
            data = base + 32'(i);
            if (to_short) ready_s = 1'b1;
            else begin
                ready = 1'b1;
                exp_hdr.push_back('{a: 5'(i), d: base + 32'(i)});
            end
        end
        @(posedge clk); #1;
        ready = 1'b0; ready_s = 1'b0;
    endtask

    task automatic push_iss(input int lo, input int hi, input bit to_short);
        for (int n = lo; n <= hi; n++) begin
            if (to_short) exp_iss_s.push_back(32'(n));
            else exp_iss.push_back(32'(n));
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        pipe.delete();
        pipe_s.delete();
    endtask

    task automatic wait_rep(input int target, input bit to_short, input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((to_short ? rep_seen_s : rep_seen) >= target) break;
        end
        chk(name, to_short ? rep_seen_s : rep_seen, target);
    endtask

    initial begin
        rst = 1'b0; ready = 1'b0; ready_s = 1'b0; data = '0; core_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Reset values
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hdr_we", {31'b0, hdr_we}, 32'd0);
        chk("rst_hdr_addr", {27'b0, hdr_addr}, 32'd0);
        chk("rst_hdr_data", hdr_data, 32'd0);
        chk("rst_core_issue", {31'b0, core_issue}, 32'd0);
        chk("rst_core_nonce", core_nonce, 32'd0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_success", {31'b0, success}, 32'd0);
        chk("rst_index", index, 32'd0);

        // Header load, first issue timing, MAX_INFLIGHT limit
        lat_en = 1'b0;
        push_iss(0, 7, 1'b0);
        load(32'h100, 1'b0);
        @(negedge clk);
        chk("first_issue", {31'b0, core_issue}, 32'd1);
        chk("first_nonce", core_nonce, 32'd0);
        repeat (12) @(negedge clk);
        chk("limit_issue_low", {31'b0, core_issue}, 32'd0);
        chk("limit_issued_all", exp_iss.size(), 32'd0);
        @(posedge clk); #1 ready = 1'b1; data = 32'hDEAD_BEEF;
        @(posedge clk); #1 ready = 1'b0;
        push_iss(8, 8, 1'b0);
        force_one = 1'b1;
        repeat (6) @(negedge clk);
        chk("run_ready_ignored_busy", {31'b0, busy}, 32'd1);
        chk("after_pop_issued_8", exp_iss.size(), 32'd0);
        chk("after_pop_issue_low", {31'b0, core_issue}, 32'd0);

        // Reset mid-RUN with 5 in flight, then a fresh load
        do_reset();
        push_iss(0, 4, 1'b0);
        load(32'h200, 1'b0);
        repeat (5) @(posedge clk);
        #1 core_stall = 1'b1;
        repeat (2) @(negedge clk);
        chk("five_issued", exp_iss.size(), 32'd0);
        do_reset();
        @(negedge clk);
        chk("midrun_rst_busy", {31'b0, busy}, 32'd0);
        chk("midrun_rst_issue", {31'b0, core_issue}, 32'd0);
        chk("midrun_rst_valid", {31'b0, valid}, 32'd0);
        core_stall = 1'b0;

        // 4-cycle datapath, winner 13, later success on 15 ignored
        lat_en = 1'b1;
        push_iss(0, 16, 1'b0);
        exp_rep.push_back('{s: 1'b1, idx: 32'd13, to: 1'b0});
        load(32'h300, 1'b0);
        wait_rep(1, 1'b0, "win_report_seen");
        repeat (3) @(negedge clk);
        chk("win_issue_count", exp_iss.size(), 32'd0);
        chk("win_idle_busy", {31'b0, busy}, 32'd0);
        chk("win_valid_once", rep_seen, 32'd1);

`ifdef SCHED_TIMEOUT_EN
        // Datapath never answers
        lat_en = 1'b0;
        push_iss(0, 7, 1'b0);
        exp_rep.push_back('{s: 1'b0, idx: 32'd7, to: 1'b1});
        load(32'h400, 1'b0);
        wait_rep(2, 1'b0, "timeout_report_seen");
        repeat (2) @(negedge clk);
        chk("timeout_issue_count", exp_iss.size(), 32'd0);
        chk("timeout_idle_busy", {31'b0, busy}, 32'd0);
`endif

        // NONCE_LAST=15 exhaustion without a winner
        push_iss(0, 15, 1'b1);
        exp_rep_s.push_back('{s: 1'b0, idx: 32'd15, to: 1'b0});
        load(32'h500, 1'b1);
        wait_rep(1, 1'b1, "short_report_seen");
        repeat (4) @(negedge clk);
        chk("short_issue_count", exp_iss_s.size(), 32'd0);
        chk("short_idle_busy", {31'b0, busy_s}, 32'd0);
        chk("short_no_wrap_issue", {31'b0, core_issue_s}, 32'd0);

        chk("hdr_all_written", exp_hdr.size(), 32'd0);
        chk("rep_all_seen", exp_rep.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
